// File: rtl/pixel_frame_writer_pkg.sv
// Shared types for the pixel frame writer: pixel layout, memory word packing
// and the writer state encoding.
`timescale 1ns/1ps
package pixel_frame_writer_pkg;

    localparam int PIXEL_W = 8;
    localparam int WORD_W  = 3 * PIXEL_W;

    typedef struct packed {
        logic [PIXEL_W-1:0] red;
        logic [PIXEL_W-1:0] green;
        logic [PIXEL_W-1:0] blue;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DRAIN,
        DONE
    } writer_state_t;

    function automatic logic [WORD_W-1:0] pack_pixel(input pixel_t p);
        return {p.red, p.green, p.blue};
    endfunction

endpackage

// File: rtl/pixel_frame_writer_if.sv
// Valid-only pixel stream (no backpressure) between median_filter and its sinks.
`timescale 1ns/1ps
interface pixel_valid_if;

    logic                          valid;
    pixel_frame_writer_pkg::pixel_t pixel;

    modport master (output valid, output pixel);
    modport slave  (input  valid, input  pixel);

endinterface

// File: rtl/pixel_sync_fifo.sv
// Synchronous FIFO with extended pointers; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
`timescale 1ns/1ps
module pixel_sync_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are
    // valid, and leaving the array out of reset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Collects one filtered frame from the pixel stream and writes it row-major to
// a frame memory through a valid/ready port, buffering stalls in a FIFO.
`timescale 1ns/1ps
module pixel_frame_writer
    import pixel_frame_writer_pkg::*;
#(
    parameter  int OUT_LEN    = 1079,
    parameter  int OUT_HEIGHT = 719,
    parameter  int FIFO_DEPTH = 16,
    localparam int FRAME_PIX  = OUT_LEN * OUT_HEIGHT,
    localparam int ADDR_W     = $clog2(FRAME_PIX)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    pixel_valid_if.slave        pixel_valid_if_i,
    output logic                mem_wr_valid_o,
    input  logic                mem_wr_ready_i,
    output logic [ADDR_W-1:0]   mem_wr_addr_o,
    output logic [WORD_W-1:0]   mem_wr_data_o,
    output logic                busy_o,
    output logic                overflow_o,
    output logic                done_o
);

    localparam int                FIFO_AW     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   FRAME_PIX_W = (ADDR_W + 1)'(FRAME_PIX);

    writer_state_t       state_q, state_d;
    logic [ADDR_W:0]     pix_cnt_q, pix_cnt_d;
    logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
    logic                overflow_q, overflow_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_AW:0]    fifo_count;
    logic [WORD_W-1:0]   fifo_head;

    pixel_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (pack_pixel(pixel_valid_if_i.pixel)),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The address MSB only sets once a power-of-two frame is fully written, so
    // gating on it keeps the port from ever presenting a wrapped address.
    assign mem_wr_valid_o = !fifo_empty && !wr_addr_q[ADDR_W];
    assign fifo_pop       = mem_wr_valid_o && mem_wr_ready_i;
    assign mem_wr_addr_o  = wr_addr_q[ADDR_W-1:0];
    assign mem_wr_data_o  = mem_wr_valid_o ? fifo_head : '0;

    assign busy_o     = (state_q == WRITE) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);
    assign overflow_o = overflow_q;

    // NOTE: every signal written here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        wr_addr_d  = fifo_pop ? wr_addr_q + 1'b1 : wr_addr_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = WRITE;
                    pix_cnt_d  = '0;
                    wr_addr_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            WRITE: begin
                if (pixel_valid_if_i.valid) begin
                    // Dropped pixels still count so the frame ends on time.
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (pix_cnt_d == FRAME_PIX_W) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_count == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            wr_addr_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            wr_addr_q  <= wr_addr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
